// File: rtl/boton_selector.sv
// rtl/boton_selector.sv - pushbutton conditioning and browse/confirm mode selector (optional AUTO_REPEAT_EN)
module boton_selector #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int N_OPTS          = 5,
    parameter int REPEAT_CYCLES   = 25_000_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_UP,
    input  logic       BTN_DOWN,
    input  logic       BTN_OK,
    output logic [2:0] BOTON_SEL,
    output logic [2:0] MODO,
    output logic       MODO_STB,
    output logic       LOCKED
);

    localparam int             CW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]  DB_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]     NMAX   = 3'(N_OPTS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BROWSE = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    // Bit order in all button vectors: [0]=UP, [1]=DOWN, [2]=OK
    logic [2:0]    s1_q, s2_q, stable_q, stable_prev_q, press_q;
    logic [CW-1:0] cnt_q [3];

    state_t     state_q;
    logic [2:0] idx_q;
    logic [2:0] boton_sel_q, modo_q;
    logic       modo_stb_q, locked_q;

    logic       up_evt, dn_evt;
    logic       ev_ok, ev_up, ev_dn;
    logic [2:0] idx_up_d, idx_dn_d;

    // Synchronize, debounce and turn accepted rising levels into one-cycle presses
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q          <= '0;
            s2_q          <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            press_q       <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q          <= {BTN_OK, BTN_DOWN, BTN_UP};
            s2_q          <= s1_q;
            stable_prev_q <= stable_q;
            press_q       <= stable_q & ~stable_prev_q;
            for (int i = 0; i < 3; i++) begin
                if (s2_q[i] == stable_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DB_MAX) begin
                    stable_q[i] <= s2_q[i];
                    cnt_q[i]    <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int            RW     = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] RP_MAX = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] hold_cnt_q;
    logic          hold_run, rep_fire;

    assign hold_run = (state_q != S_IDLE) && (stable_q[0] ^ stable_q[1]) && !press_q[2];
    assign rep_fire = hold_run && (hold_cnt_q == RP_MAX);

    // Hold timer: runs only while a single step button stays pressed outside IDLE
    always_ff @(posedge CLK) begin
        if (RST || !hold_run || rep_fire) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_q + RW'(1);
        end
    end

    // Step requests come from fresh presses plus injected repeat steps
    always_comb begin
        up_evt = press_q[0] | (rep_fire & stable_q[0]);
        dn_evt = press_q[1] | (rep_fire & stable_q[1]);
    end
`else
    // Step requests come only from fresh presses
    always_comb begin
        up_evt = press_q[0];
        dn_evt = press_q[1];
    end
`endif

    // Arbitrate: OK wins, simultaneous UP and DOWN cancel; precompute wrapped indices
    always_comb begin
        ev_ok    = press_q[2];
        ev_up    = up_evt & ~dn_evt;
        ev_dn    = dn_evt & ~up_evt;
        idx_up_d = (idx_q >= NMAX) ? 3'd1 : idx_q + 3'd1;
        idx_dn_d = (idx_q <= 3'd1) ? NMAX : idx_q - 3'd1;
    end

    // Browse/confirm FSM with all outputs registered alongside the state
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            idx_q       <= 3'd1;
            boton_sel_q <= 3'd0;
            modo_q      <= 3'd0;
            modo_stb_q  <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            modo_stb_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!ev_ok && (ev_up || ev_dn)) begin
                        state_q     <= S_BROWSE;
                        idx_q       <= 3'd1;
                        boton_sel_q <= 3'd1;
                    end
                end
                S_BROWSE: begin
                    if (ev_ok) begin
                        state_q    <= S_LOCKED;
                        modo_q     <= idx_q;
                        modo_stb_q <= 1'b1;
                        locked_q   <= 1'b1;
                    end else if (ev_up) begin
                        idx_q       <= idx_up_d;
                        boton_sel_q <= idx_up_d;
                    end else if (ev_dn) begin
                        idx_q       <= idx_dn_d;
                        boton_sel_q <= idx_dn_d;
                    end
                end
                S_LOCKED: begin
                    if (ev_ok) begin
                        state_q     <= S_IDLE;
                        idx_q       <= 3'd1;
                        boton_sel_q <= 3'd0;
                        modo_q      <= 3'd0;
                        modo_stb_q  <= 1'b1;
                        locked_q    <= 1'b0;
                    end else if (ev_up) begin
                        state_q     <= S_BROWSE;
                        idx_q       <= idx_up_d;
                        boton_sel_q <= idx_up_d;
                        locked_q    <= 1'b0;
                    end else if (ev_dn) begin
                        state_q     <= S_BROWSE;
                        idx_q       <= idx_dn_d;
                        boton_sel_q <= idx_dn_d;
                        locked_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    idx_q       <= 3'd1;
                    boton_sel_q <= 3'd0;
                    locked_q    <= 1'b0;
                end
            endcase
        end
    end

    assign BOTON_SEL = boton_sel_q;
    assign MODO      = modo_q;
    assign MODO_STB  = modo_stb_q;
    assign LOCKED    = locked_q;

endmodule
